// File: rtl/tile_fifo_pkg.sv
// Shared definitions for the tile_fifo reader and writer: pointer width and level arithmetic.
package tile_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 40;
  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned PTR_W          = ADDR_WIDTH_DEF + 1;

  // Level at which the FIFO is empty; full is 2**addr_w (see level_full).
  localparam int unsigned LEVEL_EMPTY = 0;

  // Words between two wrap-bit pointers of width ptr_w, modulo 2**ptr_w.
  function automatic logic [31:0] ptr_level(input logic [31:0] wr, input logic [31:0] rd,
                                            input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (wr - rd) & mask;
  endfunction

  function automatic logic [31:0] level_full(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/tile_fifo_skid2.sv
// Two-entry in-order buffer that absorbs the RAM read latency; head entry is registered.
module tile_fifo_skid2 import tile_fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (clear) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Occupancy unchanged; the new word goes behind whatever remains.
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_data;
          end else begin
            head_d = push_data;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = push_data;
          end else begin
            tail_d = push_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign count     = count_q;
  assign head_data = head_q;

endmodule

// File: rtl/tile_fifo_reader.sv
// Read-side controller for the tile_fifo RAM: owns the read pointer and presents a
// valid/ready stream, hiding the 1-cycle RAM read latency behind a 2-entry buffer.
module tile_fifo_reader import tile_fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   ram_level,
  output logic                  aso_valid,
  input  logic                  aso_ready,
  output logic [DATA_WIDTH-1:0] aso_data,
  output logic                  ovf_err
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] FullLevel  = PtrW'(level_full(ADDR_WIDTH));
  localparam logic [PtrW-1:0] EmptyLevel = PtrW'(LEVEL_EMPTY);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            inflight_q, inflight_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      buf_count;
  logic [2:0]      occ_next;
  logic            pop;
  logic            issue;

  assign ram_level = PtrW'(ptr_level(32'(wr_ptr), 32'(rd_ptr_q), PtrW));
  assign pop       = aso_valid & aso_ready;

  // Occupancy the buffer would have after this cycle's pop; an issue now lands next cycle.
  assign occ_next = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue    = (ram_level != EmptyLevel) && !flush && (occ_next <= 3'd1);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    ovf_d      = ovf_q;
    if (flush) begin
      rd_ptr_d = wr_ptr;
      ovf_d    = 1'b0;
    end else begin
      if (issue) begin
        rd_ptr_d   = rd_ptr_q + PtrW'(1);
        inflight_d = 1'b1;
      end
      if (ram_level > FullLevel) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
    end
  end

  tile_fifo_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q & ~flush),
    .push_data (ram_q),
    .pop       (pop),
    .clear     (flush),
    .count     (buf_count),
    .head_data (aso_data)
  );

  assign aso_valid     = (buf_count != 2'd0);
  assign rd_ptr        = rd_ptr_q;
  assign ram_read_addr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign ovf_err       = ovf_q;

endmodule
